// File: rtl/rv32_mem_arbiter.sv
// Round-robin share of one memory port between core (0) and loader/DMA (1); MEM_LATENCY+2 cycles per transaction.
// Requests wait on ready while a transaction is in flight. Access: 0=byte,1=half,2=word; exception is a 4-bit mask.
module rv32_mem_arbiter #(
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wr_data,
   input  logic        req0_wr_ena,
   input  logic [1:0]  req0_access,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wr_data,
   input  logic        req1_wr_ena,
   input  logic [1:0]  req1_access,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_rd_data,
   output logic [3:0]  rsp0_exception,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_rd_data,
   output logic [3:0]  rsp1_exception,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wr_data,
   output logic        mem_wr_ena,
   output logic [1:0]  mem_access,
   input  logic [31:0] mem_rd_data,
   input  logic [3:0]  mem_exception,
   output logic        busy,
   output logic        owner
);

   localparam logic [1:0] MEM_ACCESS_BYTE = 2'd0;
   localparam logic [2:0] CNT_INIT        = 3'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t      state_q;
   logic        owner_q;
   logic [2:0]  cnt_q;
   logic [31:0] addr_q;
   logic [31:0] wr_data_q;
   logic        wr_ena_q;
   logic [1:0]  access_q;
   logic        rsp0_valid_q;
   logic        rsp1_valid_q;
   logic [31:0] rd_data_q;
   logic [3:0]  exception_q;

   logic        grant0;
   logic        grant1;
   logic [31:0] addr_d;
   logic [31:0] wr_data_d;
   logic        wr_ena_d;
   logic [1:0]  access_d;

   // On a tie the port that did not win last time is granted.
   assign grant0 = (state_q == S_IDLE) && req0_valid && (!req1_valid || owner_q);
   assign grant1 = (state_q == S_IDLE) && req1_valid && (!req0_valid || !owner_q);

   assign addr_d    = grant1 ? req1_addr    : req0_addr;
   assign wr_data_d = grant1 ? req1_wr_data : req0_wr_data;
   assign wr_ena_d  = grant1 ? req1_wr_ena  : req0_wr_ena;
   assign access_d  = grant1 ? req1_access  : req0_access;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b1;
         cnt_q        <= 3'd0;
         addr_q       <= 32'd0;
         wr_data_q    <= 32'd0;
         wr_ena_q     <= 1'b0;
         access_q     <= MEM_ACCESS_BYTE;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rd_data_q    <= 32'd0;
         exception_q  <= 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant0 || grant1) begin
                  addr_q    <= addr_d;
                  wr_data_q <= wr_data_d;
                  wr_ena_q  <= wr_ena_d;
                  access_q  <= access_d;
                  owner_q   <= grant1;
                  cnt_q     <= CNT_INIT;
                  state_q   <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // Write strobe lives only in the first access cycle: one write per transaction.
               wr_ena_q <= 1'b0;
               if (cnt_q == 3'd0) begin
                  rd_data_q    <= mem_rd_data;
                  exception_q  <= mem_exception;
                  rsp0_valid_q <= !owner_q;
                  rsp1_valid_q <= owner_q;
                  addr_q       <= 32'd0;
                  wr_data_q    <= 32'd0;
                  access_q     <= MEM_ACCESS_BYTE;
                  state_q      <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_RESP: begin
               rsp0_valid_q <= 1'b0;
               rsp1_valid_q <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req0_ready     = grant0;
   assign req1_ready     = grant1;
   assign rsp0_valid     = rsp0_valid_q;
   assign rsp1_valid     = rsp1_valid_q;
   assign rsp0_rd_data   = rd_data_q;
   assign rsp1_rd_data   = rd_data_q;
   assign rsp0_exception = exception_q;
   assign rsp1_exception = exception_q;
   assign mem_addr       = addr_q;
   assign mem_wr_data    = wr_data_q;
   assign mem_wr_ena     = wr_ena_q;
   assign mem_access     = access_q;
   assign busy           = (state_q != S_IDLE);
   assign owner          = owner_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: instance 0 runs MEM_LATENCY=1, instance 1 runs MEM_LATENCY=3.
module tb_rv32_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req0_valid, req1_valid, req0_ready, req1_ready;
   logic [1:0]  req0_wr_ena, req1_wr_ena, rsp0_valid, rsp1_valid;
   logic [1:0]  mem_wr_ena, busy, owner;
   logic [31:0] req0_addr [2];
   logic [31:0] req0_wr_data [2];
   logic [31:0] req1_addr [2];
   logic [31:0] req1_wr_data [2];
   logic [31:0] rsp0_rd_data [2];
   logic [31:0] rsp1_rd_data [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_wr_data [2];
   logic [31:0] mem_rd_data [2];
   logic [1:0]  req0_access [2];
   logic [1:0]  req1_access [2];
   logic [1:0]  mem_access [2];
   logic [3:0]  rsp0_exception [2];
   logic [3:0]  rsp1_exception [2];
   logic [3:0]  mem_exception [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 1 : 3;
      rv32_mem_arbiter #(.MEM_LATENCY(LAT)) u_dut (
         .clk           (clk),
         .rst           (rst),
         .req0_valid    (req0_valid[g]),
         .req0_ready    (req0_ready[g]),
         .req0_addr     (req0_addr[g]),
         .req0_wr_data  (req0_wr_data[g]),
         .req0_wr_ena   (req0_wr_ena[g]),
         .req0_access   (req0_access[g]),
         .req1_valid    (req1_valid[g]),
         .req1_ready    (req1_ready[g]),
         .req1_addr     (req1_addr[g]),
         .req1_wr_data  (req1_wr_data[g]),
         .req1_wr_ena   (req1_wr_ena[g]),
         .req1_access   (req1_access[g]),
         .rsp0_valid    (rsp0_valid[g]),
         .rsp0_rd_data  (rsp0_rd_data[g]),
         .rsp0_exception(rsp0_exception[g]),
         .rsp1_valid    (rsp1_valid[g]),
         .rsp1_rd_data  (rsp1_rd_data[g]),
         .rsp1_exception(rsp1_exception[g]),
         .mem_addr      (mem_addr[g]),
         .mem_wr_data   (mem_wr_data[g]),
         .mem_wr_ena    (mem_wr_ena[g]),
         .mem_access    (mem_access[g]),
         .mem_rd_data   (mem_rd_data[g]),
         .mem_exception (mem_exception[g]),
         .busy          (busy[g]),
         .owner         (owner[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int we_cnt;
      int ngrant;
      int viol;
      int rsp_cnt;
      logic drop0, drop1;

      rst = 1'b0;
      req0_valid = '0; req1_valid = '0; req0_wr_ena = '0; req1_wr_ena = '0;
      for (int g = 0; g < 2; g++) begin
         req0_addr[g] = '0; req0_wr_data[g] = '0; req0_access[g] = '0;
         req1_addr[g] = '0; req1_wr_data[g] = '0; req1_access[g] = '0;
         mem_rd_data[g] = '0; mem_exception[g] = '0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      for (int g = 0; g < 2; g++) begin
         chk("rst_busy", 32'(busy[g]), 32'd0);
         chk("rst_owner", 32'(owner[g]), 32'd1);
         chk("rst_access", 32'(mem_access[g]), 32'd0);
         chk("rst_addr", mem_addr[g], 32'd0);
      end
      rst = 1'b1;

      // Idle after release
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #2;
         for (int g = 0; g < 2; g++) begin
            chk("idle_ctl", 32'({busy[g], mem_wr_ena[g], req0_ready[g], req1_ready[g],
                                rsp0_valid[g], rsp1_valid[g]}), 32'd0);
            chk("idle_addr", mem_addr[g], 32'd0);
         end
      end

      // Port 0 read, latency 1
      @(posedge clk); #1;
      req0_valid[0] = 1'b1; req0_addr[0] = 32'h1000_0004; req0_wr_ena[0] = 1'b0;
      req0_access[0] = 2'd2; mem_rd_data[0] = 32'hDEAD_BEEF;
      #1;
      chk("t2_ready0_c0", 32'(req0_ready[0]), 32'd1);
      chk("t2_ready1_c0", 32'(req1_ready[0]), 32'd0);
      @(posedge clk); #1;
      req0_valid[0] = 1'b0;
      #1;
      chk("t2_addr_c1", mem_addr[0], 32'h1000_0004);
      chk("t2_access_c1", 32'(mem_access[0]), 32'd2);
      chk("t2_we_c1", 32'(mem_wr_ena[0]), 32'd0);
      chk("t2_busy_c1", 32'(busy[0]), 32'd1);
      chk("t2_rsp0_c1", 32'(rsp0_valid[0]), 32'd0);
      @(posedge clk); #2;
      chk("t2_rsp0_c2", 32'(rsp0_valid[0]), 32'd1);
      chk("t2_rdata_c2", rsp0_rd_data[0], 32'hDEAD_BEEF);
      chk("t2_rsp1_c2", 32'(rsp1_valid[0]), 32'd0);
      chk("t2_owner", 32'(owner[0]), 32'd0);
      @(posedge clk); #2;
      chk("t2_busy_c3", 32'(busy[0]), 32'd0);
      chk("t2_rsp0_c3", 32'(rsp0_valid[0]), 32'd0);

      // Port 1 write, latency 3
      @(posedge clk); #1;
      req1_valid[1] = 1'b1; req1_addr[1] = 32'h1000_0010; req1_wr_data[1] = 32'h55AA_55AA;
      req1_wr_ena[1] = 1'b1; req1_access[1] = 2'd2;
      #1;
      chk("t3_ready1_c0", 32'(req1_ready[1]), 32'd1);
      we_cnt = 0;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (c == 1) req1_valid[1] = 1'b0;
         #1;
         we_cnt += int'(mem_wr_ena[1]);
         if (c == 1) chk("t3_we_c1", 32'(mem_wr_ena[1]), 32'd1);
         if (c <= 3) begin
            chk("t3_addr_hold", mem_addr[1], 32'h1000_0010);
            chk("t3_wdata_hold", mem_wr_data[1], 32'h55AA_55AA);
            chk("t3_ready_busy", 32'({req0_ready[1], req1_ready[1]}), 32'd0);
         end
         if (c < 4) chk("t3_rsp1_early", 32'(rsp1_valid[1]), 32'd0);
         if (c == 4) begin
            chk("t3_rsp1_c4", 32'(rsp1_valid[1]), 32'd1);
            chk("t3_rsp0_c4", 32'(rsp0_valid[1]), 32'd0);
         end
         if (c == 5) chk("t3_busy_c5", 32'(busy[1]), 32'd0);
      end
      chk("t3_we_count", 32'(we_cnt), 32'd1);
      req1_wr_ena[1] = 1'b0;

      // Both ports contending from reset, latency 3
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      req0_addr[1] = 32'h2000_0000; req1_addr[1] = 32'h3000_0000;
      req0_valid[1] = 1'b1; req1_valid[1] = 1'b1;
      ngrant = 0; viol = 0; drop0 = 1'b0; drop1 = 1'b0;
      for (int c = 0; c < 60 && ngrant < 4; c++) begin
         #1;
         if ((req0_ready[1] || req1_ready[1]) && busy[1]) viol++;
         if (req0_ready[1] && req1_ready[1]) viol++;
         if (req0_ready[1]) begin
            chk("t4_grant_order", 32'd0, 32'(ngrant % 2));
            ngrant++;
            drop0 = 1'b1;
         end
         if (req1_ready[1]) begin
            chk("t4_grant_order", 32'd1, 32'(ngrant % 2));
            ngrant++;
            drop1 = 1'b1;
         end
         @(posedge clk); #1;
         if (drop0) req0_valid[1] = 1'b0;
         if (drop1) req1_valid[1] = 1'b0;
         drop0 = 1'b0; drop1 = 1'b0;
         if (rsp0_valid[1]) req0_valid[1] = 1'b1;
         if (rsp1_valid[1]) req1_valid[1] = 1'b1;
      end
      chk("t4_grant_count", 32'(ngrant), 32'd4);
      chk("t4_ready_while_busy", 32'(viol), 32'd0);
      req0_valid[1] = 1'b0; req1_valid[1] = 1'b0;
      repeat (6) @(posedge clk);

      // Exception on port 0, latency 1
      #1;
      req0_valid[0] = 1'b1; req0_addr[0] = 32'h1000_0008; req0_wr_ena[0] = 1'b0;
      mem_exception[0] = 4'hA; mem_rd_data[0] = 32'h0BAD_0BAD;
      #1;
      chk("t5_ready0", 32'(req0_ready[0]), 32'd1);
      @(posedge clk); #1;
      req0_valid[0] = 1'b0;
      @(posedge clk); #2;
      chk("t5_rsp0_valid", 32'(rsp0_valid[0]), 32'd1);
      chk("t5_rsp0_exc", 32'(rsp0_exception[0]), 32'hA);
      chk("t5_rsp1_valid", 32'(rsp1_valid[0]), 32'd0);
      mem_exception[0] = 4'h0;

      // Reset during access of a port 1 read, latency 3
      @(posedge clk); #1;
      req1_valid[1] = 1'b1; req1_addr[1] = 32'h1000_0020; req1_wr_ena[1] = 1'b0;
      mem_rd_data[1] = 32'h1234_5678;
      #1;
      chk("t6_ready1", 32'(req1_ready[1]), 32'd1);
      @(posedge clk); #1;
      req1_valid[1] = 1'b0;
      @(posedge clk); #1;
      chk("t6_busy_pre", 32'(busy[1]), 32'd1);
      rst = 1'b0;
      #1;
      chk("t6_busy_rst", 32'(busy[1]), 32'd0);
      chk("t6_addr_rst", mem_addr[1], 32'd0);
      chk("t6_owner_rst", 32'(owner[1]), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      rsp_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #2;
         rsp_cnt += int'(rsp1_valid[1]) + int'(rsp0_valid[1]);
      end
      chk("t6_no_rsp", 32'(rsp_cnt), 32'd0);
      #1;
      req1_valid[1] = 1'b1; req1_addr[1] = 32'h1000_0024; mem_rd_data[1] = 32'hCAFE_F00D;
      #1;
      chk("t6_fresh_ready1", 32'(req1_ready[1]), 32'd1);
      @(posedge clk); #1;
      req1_valid[1] = 1'b0;
      #1;
      chk("t6_fresh_addr", mem_addr[1], 32'h1000_0024);
      repeat (3) @(posedge clk);
      #2;
      chk("t6_fresh_rsp1", 32'(rsp1_valid[1]), 32'd1);
      chk("t6_fresh_rdata", rsp1_rd_data[1], 32'hCAFE_F00D);
      @(posedge clk); #2;
      chk("t6_fresh_idle", 32'(busy[1]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
